// File: rtl/traffic_ctrl_param.sv
// Two-road intersection controller: tick-driven phase sequencer with latched
// pedestrian/left-turn requests, minimum-green guard and emergency/outage flashing.
module traffic_ctrl_param #(
  parameter int DIV        = 2,
  parameter int CW         = 32,
  parameter int T_GREEN    = 300,
  parameter int T_YELLOW   = 50,
  parameter int T_ALLRED   = 25,
  parameter int T_PED      = 600,
  parameter int T_TURN     = 300,
  parameter int T_EMERG    = 300,
  parameter int T_FLASH    = 50,
  parameter int T_MINGREEN = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Emergency,
  input  logic       PowerOutage,
  input  logic       Pedestrian,
  input  logic       LeftTurn,
  output logic [2:0] Light1,
  output logic [2:0] Light2,
  output logic       TurnLight,
  output logic       Walk,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_G2 = 4'd1, S_Y2 = 4'd2, S_AR1 = 4'd3, S_G1 = 4'd4, S_Y1 = 4'd5,
    S_AR2 = 4'd6, S_PED = 4'd7, S_TURN = 4'd8, S_FLASH = 4'd9, S_EMERG = 4'd10
  } state_t;

  typedef enum logic [2:0] {R_NORMAL = 3'd0, R_PED = 3'd1, R_TURN = 3'd2} route_t;

  localparam logic [CW-1:0] L_DIV    = CW'(DIV - 1);
  localparam logic [CW-1:0] L_GREEN  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] L_YELLOW = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] L_ALLRED = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] L_PED    = CW'(T_PED - 1);
  localparam logic [CW-1:0] L_TURN   = CW'(T_TURN - 1);
  localparam logic [CW-1:0] L_EMERG  = CW'(T_EMERG - 1);
  localparam logic [CW-1:0] L_FLASH  = CW'(T_FLASH - 1);
  localparam logic [CW-1:0] L_MIN    = CW'(T_MINGREEN - 1);

  state_t        r_state, w_next;
  route_t        r_route, w_route;
  logic [CW-1:0] r_pre, r_cnt, r_fcnt;
  logic          r_flash, r_ped_req, r_turn_req, r_ped_g1;
  logic          w_tick, w_load, w_min_ok, w_ped_clr, w_turn_clr;

  assign w_tick     = (r_pre == L_DIV);
  assign w_min_ok   = (r_cnt >= L_MIN);
  assign w_ped_clr  = w_load && (w_next == S_PED);
  assign w_turn_clr = w_load && (w_next == S_TURN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_G2;
      r_route    <= R_NORMAL;
      r_pre      <= '0;
      r_cnt      <= '0;
      r_fcnt     <= '0;
      r_flash    <= 1'b1;
      r_ped_req  <= 1'b0;
      r_turn_req <= 1'b0;
      r_ped_g1   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_route    <= w_route;
      r_pre      <= w_tick ? '0 : r_pre + CW'(1);
      r_ped_req  <= Pedestrian | (r_ped_req & ~w_ped_clr);
      r_turn_req <= LeftTurn | (r_turn_req & ~w_turn_clr);
      if (w_ped_clr) r_ped_g1 <= (r_state == S_Y2);
      // Entry (including an EMERG restart) reloads cnt and the flash phase.
      if (w_load) begin
        r_cnt   <= '0;
        r_fcnt  <= '0;
        r_flash <= 1'b1;
      end else if (w_tick) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_state == S_FLASH || r_state == S_EMERG) begin
          if (r_fcnt == L_FLASH) begin
            r_fcnt  <= '0;
            r_flash <= ~r_flash;
          end else begin
            r_fcnt <= r_fcnt + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_route = r_route;
    w_load  = 1'b0;
    if (!(r_state inside {S_G2, S_Y2, S_AR1, S_G1, S_Y1, S_AR2, S_PED, S_TURN, S_FLASH, S_EMERG})) begin
      w_next = S_G2;
      w_load = 1'b1;
    end else if (w_tick) begin
      if (Emergency && r_state != S_EMERG) begin
        w_next = S_EMERG;
        w_load = 1'b1;
      end else if (PowerOutage && r_state != S_FLASH && r_state != S_EMERG) begin
        w_next = S_FLASH;
        w_load = 1'b1;
      end else begin
        case (r_state)
          S_G2: if (r_cnt == L_GREEN || (w_min_ok && (r_ped_req || r_turn_req))) begin
            w_next  = S_Y2;
            w_load  = 1'b1;
            w_route = r_ped_req ? R_PED : (r_turn_req ? R_TURN : R_NORMAL);
          end
          S_G1: if (r_cnt == L_GREEN || (w_min_ok && r_ped_req)) begin
            w_next  = S_Y1;
            w_load  = 1'b1;
            w_route = r_ped_req ? R_PED : R_NORMAL;
          end
          S_Y2: if (r_cnt == L_YELLOW) begin
            w_next = (r_route == R_PED) ? S_PED : ((r_route == R_TURN) ? S_TURN : S_AR1);
            w_load = 1'b1;
          end
          S_Y1: if (r_cnt == L_YELLOW) begin
            w_next = (r_route == R_PED) ? S_PED : S_AR2;
            w_load = 1'b1;
          end
          S_AR1: if (r_cnt == L_ALLRED) begin w_next = S_G1; w_load = 1'b1; end
          S_AR2: if (r_cnt == L_ALLRED) begin w_next = S_G2; w_load = 1'b1; end
          S_PED: if (r_cnt == L_PED) begin
            w_next = r_ped_g1 ? S_G1 : S_G2;
            w_load = 1'b1;
          end
          S_TURN: if (r_cnt == L_TURN) begin w_next = S_G1; w_load = 1'b1; end
          S_EMERG: if (r_cnt == L_EMERG) begin
            w_next = Emergency ? S_EMERG : S_G2;
            w_load = 1'b1;
          end
          S_FLASH: if (!PowerOutage) begin w_next = S_G2; w_load = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    Light1    = 3'b100;
    Light2    = 3'b100;
    TurnLight = 1'b0;
    Walk      = 1'b0;
    state     = r_state;
    case (r_state)
      S_G2:    Light2 = 3'b001;
      S_Y2:    Light2 = 3'b010;
      S_G1:    Light1 = 3'b001;
      S_Y1:    Light1 = 3'b010;
      S_PED:   Walk = 1'b1;
      S_TURN:  TurnLight = 1'b1;
      S_FLASH: begin
        Light1 = {1'b0, r_flash, 1'b0};
        Light2 = {1'b0, r_flash, 1'b0};
      end
      S_EMERG: begin
        Light1 = {r_flash, 2'b00};
        Light2 = {r_flash, 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: normal cycle, pedestrian/turn routing,
// emergency and outage flashing, and reset in the middle of a turn phase.
module tb_traffic_ctrl_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Emergency = 1'b0, PowerOutage = 1'b0, Pedestrian = 1'b0, LeftTurn = 1'b0;
  logic [2:0] Light1, Light2;
  logic       TurnLight, Walk;
  logic [3:0] state;
  int         checks = 0;
  int         errors = 0;

  traffic_ctrl_param #(
    .DIV(2), .T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1),
    .T_MINGREEN(2), .T_FLASH(2), .T_EMERG(6)
  ) dut (
    .clk(clk), .rst(rst), .Emergency(Emergency), .PowerOutage(PowerOutage),
    .Pedestrian(Pedestrian), .LeftTurn(LeftTurn), .Light1(Light1), .Light2(Light2),
    .TurnLight(TurnLight), .Walk(Walk), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_change(output int n);
    logic [3:0] cur;
    cur = state;
    n = 0;
    do begin step(); n++; end while (state == cur && n < 5000);
  endtask

  task automatic wait_state(input logic [3:0] s, output int n);
    n = 0;
    while (state !== s && n < 5000) begin step(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL reset_state got=%0d exp=1", state); end
    checks++; if ({Light1, Light2} !== 6'b100_001) begin errors++; $display("FAIL reset_lights got=%b exp=100001", {Light1, Light2}); end
    checks++; if ({TurnLight, Walk} !== 2'b00) begin errors++; $display("FAIL reset_turn_walk got=%b exp=00", {TurnLight, Walk}); end
    checks++; if ({dut.r_ped_req, dut.r_turn_req, dut.r_flash} !== 3'b001) begin errors++; $display("FAIL reset_latch_flash got=%b exp=001", {dut.r_ped_req, dut.r_turn_req, dut.r_flash}); end
  endtask

  task automatic test_normal();
    logic [3:0] es [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};
    int         ed [6] = '{8, 4, 2, 8, 4, 2};
    logic [5:0] el [6] = '{6'b100_010, 6'b100_100, 6'b001_100, 6'b010_100, 6'b100_100, 6'b100_001};
    int n;
    for (int i = 0; i < 6; i++) begin
      wait_change(n);
      checks++; if (state !== es[i]) begin errors++; $display("FAIL normal_state[%0d] got=%0d exp=%0d", i, state, es[i]); end
      checks++; if (n != ed[i]) begin errors++; $display("FAIL normal_dwell[%0d] got=%0d exp=%0d", i, n, ed[i]); end
      checks++; if ({Light1, Light2} !== el[i]) begin errors++; $display("FAIL normal_lights[%0d] got=%b exp=%b", i, {Light1, Light2}, el[i]); end
    end
  endtask

  task automatic test_ped();
    int n;
    Pedestrian = 1'b1; step(); Pedestrian = 1'b0;
    checks++; if (dut.r_ped_req !== 1'b1) begin errors++; $display("FAIL ped_latch got=%b exp=1", dut.r_ped_req); end
    wait_change(n);
    checks++; if (state !== 4'd2 || n + 1 != 4) begin errors++; $display("FAIL ped_g2_early got state=%0d dwell=%0d exp state=2 dwell=4", state, n + 1); end
    wait_change(n);
    checks++; if (state !== 4'd7 || Walk !== 1'b1) begin errors++; $display("FAIL ped_enter got state=%0d walk=%b exp 7/1", state, Walk); end
    checks++; if (dut.r_ped_req !== 1'b0) begin errors++; $display("FAIL ped_clear got=%b exp=0", dut.r_ped_req); end
    wait_change(n);
    checks++; if (state !== 4'd4 || n != 1200 || Walk !== 1'b0) begin errors++; $display("FAIL ped_exit got state=%0d dwell=%0d walk=%b exp 4/1200/0", state, n, Walk); end
  endtask

  task automatic test_back_to_back();
    int n;
    wait_state(4'd1, n);
    Pedestrian = 1'b1; LeftTurn = 1'b1; step(); Pedestrian = 1'b0; LeftTurn = 1'b0;
    wait_change(n);
    checks++; if (state !== 4'd2 || n + 1 != 4) begin errors++; $display("FAIL b2b_g2_early got state=%0d dwell=%0d exp 2/4", state, n + 1); end
    wait_change(n);
    checks++; if (state !== 4'd7 || dut.r_turn_req !== 1'b1) begin errors++; $display("FAIL b2b_ped_first got state=%0d turn_req=%b exp 7/1", state, dut.r_turn_req); end
    wait_change(n);
    checks++; if (state !== 4'd4 || n != 1200) begin errors++; $display("FAIL b2b_ped_exit got state=%0d dwell=%0d exp 4/1200", state, n); end
    wait_change(n);
    checks++; if (state !== 4'd5 || n != 8) begin errors++; $display("FAIL b2b_g1_full got state=%0d dwell=%0d exp 5/8", state, n); end
    wait_change(n);
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL b2b_y1_route got=%0d exp=6", state); end
    wait_change(n);
    wait_change(n);
    checks++; if (state !== 4'd2 || n != 4) begin errors++; $display("FAIL b2b_g2_turn got state=%0d dwell=%0d exp 2/4", state, n); end
    wait_change(n);
    checks++; if (state !== 4'd8 || TurnLight !== 1'b1 || dut.r_turn_req !== 1'b0) begin errors++; $display("FAIL b2b_turn got state=%0d arrow=%b req=%b exp 8/1/0", state, TurnLight, dut.r_turn_req); end
    wait_change(n);
    checks++; if (state !== 4'd4 || n != 600 || TurnLight !== 1'b0) begin errors++; $display("FAIL b2b_turn_exit got state=%0d dwell=%0d arrow=%b exp 4/600/0", state, n, TurnLight); end
  endtask

  task automatic test_emergency();
    logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    wait_state(4'd5, n);
    Emergency = 1'b1; step(); step(); Emergency = 1'b0;
    checks++; if (state !== 4'd10) begin errors++; $display("FAIL emerg_enter got=%0d exp=10", state); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (Light1 !== {pat[i], 2'b00} || Light2 !== {pat[i], 2'b00}) begin errors++; $display("FAIL emerg_pat[%0d] got=%b/%b exp=%b00", i, Light1, Light2, pat[i]); end
      step(); step();
    end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL emerg_exit got=%0d exp=1", state); end
  endtask

  task automatic test_flash();
    logic pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int n;
    Pedestrian = 1'b1; step(); Pedestrian = 1'b0;
    wait_state(4'd7, n);
    PowerOutage = 1'b1; step(); step();
    checks++; if (state !== 4'd9) begin errors++; $display("FAIL flash_enter got=%0d exp=9", state); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (Light1 !== {1'b0, pat[i], 1'b0} || Light2 !== {1'b0, pat[i], 1'b0}) begin errors++; $display("FAIL flash_pat[%0d] got=%b/%b exp=0%b0", i, Light1, Light2, pat[i]); end
      if (i < 4) begin step(); step(); end
    end
    Emergency = 1'b1; step(); step();
    checks++; if (state !== 4'd10 || Light1 !== 3'b100) begin errors++; $display("FAIL flash_to_emerg got state=%0d l1=%b exp 10/100", state, Light1); end
    Emergency = 1'b0; PowerOutage = 1'b0;
    wait_change(n);
    checks++; if (state !== 4'd1 || n != 12) begin errors++; $display("FAIL flash_emerg_exit got state=%0d dwell=%0d exp 1/12", state, n); end
  endtask

  task automatic test_reset_mid_turn();
    int n;
    LeftTurn = 1'b1; step(); LeftTurn = 1'b0;
    wait_state(4'd8, n);
    repeat (50) step();
    Pedestrian = 1'b1; step(); Pedestrian = 1'b0;
    checks++; if (state !== 4'd8 || dut.r_ped_req !== 1'b1) begin errors++; $display("FAIL rst_pre got state=%0d ped_req=%b exp 8/1", state, dut.r_ped_req); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (state !== 4'd1 || TurnLight !== 1'b0 || {Light1, Light2} !== 6'b100_001) begin errors++; $display("FAIL rst_mid_out got state=%0d arrow=%b lights=%b exp 1/0/100001", state, TurnLight, {Light1, Light2}); end
    checks++; if ({dut.r_ped_req, dut.r_turn_req} !== 2'b00 || dut.r_cnt !== '0 || dut.r_pre !== '0) begin errors++; $display("FAIL rst_mid_regs got latches=%b cnt=%0d pre=%0d exp 00/0/0", {dut.r_ped_req, dut.r_turn_req}, dut.r_cnt, dut.r_pre); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ped();
    test_back_to_back();
    test_emergency();
    test_flash();
    test_reset_mid_turn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
